iter_shifter: RTL

//   Parametrised, multi-mode iterative shifter. Generalises the fixed 7-bit

---
 rtl/iter_shifter_if.sv | 27 ++
 rtl/iter_shifter.sv | 115 +++++++++++
 2 files changed

// File: rtl/iter_shifter_if.sv
// Request/result handshake bundle for iter_shifter.
// master = operand/consumer side, slave = the shifter.
interface iter_shifter_if #(
  parameter int WIDTH = 7,
  parameter int AW    = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [AW-1:0]    in_amt;
  logic [1:0]       in_op;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_carry;
  logic             out_zero;

  modport master (
    output in_valid, in_data, in_amt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_carry, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_amt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_carry, out_zero
  );
endinterface

// File: rtl/iter_shifter.sv
// Iterative WIDTH-bit shifter (LSL/LSR/ASR/ROL), one bit per clock with carry/zero flags.
// Define SHIFT_STEP4_EN to take 4-bit steps while at least 4 shifts remain.
module iter_shifter #(
  parameter int WIDTH = 7,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          reset_n,
  iter_shifter_if.slave bus
);
  localparam int CW = AW + 1;
`ifdef SHIFT_STEP4_EN
  localparam int MAXSTEP = 4;
`else
  localparam int MAXSTEP = 1;
`endif

  generate
    if (WIDTH < 2) begin : g_w_chk
      $error("iter_shifter: WIDTH must be >= 2");
    end
    if ((2 ** AW) < WIDTH) begin : g_aw_chk
      $error("iter_shifter: 2**AW must be >= WIDTH");
    end
`ifdef SHIFT_STEP4_EN
    if (WIDTH < 4) begin : g_s4_chk
      $error("iter_shifter: SHIFT_STEP4_EN needs WIDTH >= 4");
    end
`endif
  endgenerate

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] data, data_nx;
  logic             carry, carry_nx;
  logic [CW-1:0]    cnt, cnt_nx;
  logic [1:0]       op, op_nx;
  logic [CW-1:0]    amt_ext, n, step;
  logic [WIDTH:0]   sh;

  // Single-bit step; result is {carry_out, data_out}.
  function automatic logic [WIDTH:0] step1(input logic [1:0] o, input logic [WIDTH-1:0] d);
    logic [WIDTH:0] r;
    case (o)
      2'd0:    r = {d[WIDTH-1], d[WIDTH-2:0], 1'b0};
      2'd1:    r = {d[0], 1'b0, d[WIDTH-1:1]};
      2'd2:    r = {d[0], d[WIDTH-1], d[WIDTH-1:1]};
      default: r = {d[WIDTH-1], d[WIDTH-2:0], d[WIDTH-1]};
    endcase
    return r;
  endfunction

  always_comb begin
    amt_ext = {1'b0, bus.in_amt};
    if (bus.in_op == 2'd3) n = amt_ext % CW'(WIDTH);
    else                   n = (amt_ext > CW'(WIDTH)) ? CW'(WIDTH) : amt_ext;
`ifdef SHIFT_STEP4_EN
    step = (cnt >= CW'(4)) ? CW'(4) : CW'(1);
`else
    step = CW'(1);
`endif
    // Chain up to MAXSTEP single-bit steps; carry ends up as the last bit out.
    sh = {carry, data};
    for (int i = 0; i < MAXSTEP; i++)
      if (CW'(i) < step) sh = step1(op, sh[WIDTH-1:0]);
  end

  always_comb begin
    state_nx = state;
    data_nx  = data;
    carry_nx = carry;
    cnt_nx   = cnt;
    op_nx    = op;
    case (state)
      IDLE: if (bus.in_valid) begin
        data_nx  = bus.in_data;
        op_nx    = bus.in_op;
        carry_nx = 1'b0;
        cnt_nx   = n;
        state_nx = (n != '0) ? SHIFT : DONE;
      end
      SHIFT: begin
        data_nx  = sh[WIDTH-1:0];
        carry_nx = sh[WIDTH];
        cnt_nx   = cnt - step;
        if (cnt == step) state_nx = DONE;
      end
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      data  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      op    <= 2'd0;
    end else begin
      state <= state_nx;
      data  <= data_nx;
      carry <= carry_nx;
      cnt   <= cnt_nx;
      op    <= op_nx;
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = data;
  assign bus.out_carry = carry;
  assign bus.out_zero  = (data == '0);
endmodule
